// File: rtl/fpu_result_fifo.sv
// Result queue behind the FP adder. Each accepted result word and its status
// go into a DEPTH-entry FIFO, which drives a valid/ready port. Also keeps
// sticky exception flags over accepted results, and a sticky drop indicator.
module fpu_result_fifo #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid_in,
    input  logic [31:0]      res_data_in,
    input  logic [3:0]       res_status_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [3:0]       out_status,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [3:0]       flags_acc,
    input  logic             flags_clr,
    output logic             drop_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // Bit 3 (EXACT) is an AND-accumulator, so its cleared value is 1.
    localparam logic [3:0] FLAGS_INIT = 4'b1000;

    logic [35:0]      mem_q [DEPTH];
    logic [35:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       flags_q, flags_d;
    logic             drop_q, drop_d;
    logic             push, pop, drop;
    logic [3:0]       flags_base;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign out_valid  = !empty;
    assign count      = count_q;
    assign flags_acc  = flags_q;
    assign drop_err   = drop_q;
    // Head is forced to zero when nothing is queued, independent of stale storage.
    assign out_data   = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
    assign out_status = out_valid ? mem_q[rd_ptr_q][35:32] : 4'h0;

    // Handshake decode, next-state for storage, pointers, occupancy and sticky state.
    always_comb begin
        pop      = out_valid && out_ready;
        // A full FIFO still accepts a result when the head leaves in the same cycle.
        push     = res_valid_in && (!full || pop);
        drop     = res_valid_in && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {res_status_in, res_data_in};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear first, then fold in a same-cycle accepted result.
        flags_base = flags_clr ? FLAGS_INIT : flags_q;
        flags_d    = flags_base;
        if (push) begin
            flags_d = {flags_base[3] & res_status_in[3],
                       flags_base[2:0] | res_status_in[2:0]};
        end

        drop_d = flags_clr ? 1'b0 : drop_q;
        if (drop) begin
            drop_d = 1'b1;
        end
    end

    // State registers; reset flushes contents as well as pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= FLAGS_INIT;
            drop_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Self-checking bench for fpu_result_fifo: directed vector table, hand-written
// wrap and mid-cycle reset sequences, then random traffic against a queue model.
module tb_fpu_result_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             res_valid_in = 1'b0;
    logic [31:0]      res_data_in = '0;
    logic [3:0]       res_status_in = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [3:0]       out_status;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic [3:0]       flags_acc;
    logic             flags_clr = 1'b0;
    logic             drop_err;

    int nvec = 0;
    int nerr = 0;

    fpu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .res_valid_in(res_valid_in), .res_data_in(res_data_in), .res_status_in(res_status_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_status(out_status),
        .count(count), .full(full), .empty(empty),
        .flags_acc(flags_acc), .flags_clr(flags_clr), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  s;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_stat;
        int          e_cnt;
        logic [3:0]  e_flags;
        logic        e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                             input logic [3:0] es, input int ec, input logic [3:0] ef,
                             input logic edr);
        chk({tag, ".out_valid"},  32'(out_valid),  32'(ev));
        chk({tag, ".out_data"},   out_data,        ed);
        chk({tag, ".out_status"}, 32'(out_status), 32'(es));
        chk({tag, ".count"},      32'(count),      32'(ec));
        chk({tag, ".full"},       32'(full),       32'(ec == DEPTH));
        chk({tag, ".empty"},      32'(empty),      32'(ec == 0));
        chk({tag, ".flags_acc"},  32'(flags_acc),  32'(ef));
        chk({tag, ".drop_err"},   32'(drop_err),   32'(edr));
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic [3:0] s,
                       input logic rdy, input logic clr, input logic ev,
                       input logic [31:0] ed, input logic [3:0] es, input int ec,
                       input logic [3:0] ef, input logic edr);
        vec_t t;
        t.v = v; t.d = d; t.s = s; t.rdy = rdy; t.clr = clr;
        t.e_valid = ev; t.e_data = ed; t.e_stat = es; t.e_cnt = ec;
        t.e_flags = ef; t.e_drop = edr;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s,
                         input logic rdy, input logic clr);
        res_valid_in = v; res_data_in = d; res_status_in = s;
        out_ready = rdy; flags_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reference model: plain queue plus sticky state
    logic [35:0] mq[$];
    logic [3:0]  mflags;
    logic        mdrop;

    initial begin
        // Test 1: single result in and out
        add(1, 32'h3F800000, 4'b1000, 0, 0,  1, 32'h3F800000, 4'b1000, 1, 4'b1000, 0);
        add(0, 32'h0,        4'b0000, 1, 0,  0, 32'h0,        4'b0000, 0, 4'b1000, 0);
        // Test 2: fill, overflow drop, drain in order
        add(1, 32'h00000001, 4'b1000, 0, 0,  1, 32'h00000001, 4'b1000, 1, 4'b1000, 0);
        add(1, 32'h00000002, 4'b1000, 0, 0,  1, 32'h00000001, 4'b1000, 2, 4'b1000, 0);
        add(1, 32'h00000003, 4'b1000, 0, 0,  1, 32'h00000001, 4'b1000, 3, 4'b1000, 0);
        add(1, 32'h00000004, 4'b1000, 0, 0,  1, 32'h00000001, 4'b1000, 4, 4'b1000, 0);
        add(1, 32'h40000000, 4'b0010, 0, 0,  1, 32'h00000001, 4'b1000, 4, 4'b1000, 1);
        add(0, 32'h0,        4'b0000, 1, 0,  1, 32'h00000002, 4'b1000, 3, 4'b1000, 1);
        add(0, 32'h0,        4'b0000, 1, 0,  1, 32'h00000003, 4'b1000, 2, 4'b1000, 1);
        add(0, 32'h0,        4'b0000, 1, 0,  1, 32'h00000004, 4'b1000, 1, 4'b1000, 1);
        add(0, 32'h0,        4'b0000, 1, 0,  0, 32'h0,        4'b0000, 0, 4'b1000, 1);
        // Empty and ready: nothing happens; then clear the drop indicator
        add(0, 32'h0,        4'b0000, 1, 0,  0, 32'h0,        4'b0000, 0, 4'b1000, 1);
        add(0, 32'h0,        4'b0000, 0, 1,  0, 32'h0,        4'b0000, 0, 4'b1000, 0);
        // Test 4: flag accumulation and clear-with-push
        add(1, 32'hAAAA0001, 4'b0101, 0, 0,  1, 32'hAAAA0001, 4'b0101, 1, 4'b0101, 0);
        add(1, 32'hAAAA0002, 4'b1000, 0, 0,  1, 32'hAAAA0001, 4'b0101, 2, 4'b0101, 0);
        add(1, 32'hAAAA0003, 4'b0100, 0, 1,  1, 32'hAAAA0001, 4'b0101, 3, 4'b0100, 0);
        add(0, 32'h0,        4'b0000, 1, 0,  1, 32'hAAAA0002, 4'b1000, 2, 4'b0100, 0);
        add(0, 32'h0,        4'b0000, 1, 0,  1, 32'hAAAA0003, 4'b0100, 1, 4'b0100, 0);
        add(0, 32'h0,        4'b0000, 1, 0,  0, 32'h0,        4'b0000, 0, 4'b0100, 0);
        // Test 5: overflow result, then clear while popping it
        add(1, 32'h7F800000, 4'b0101, 0, 0,  1, 32'h7F800000, 4'b0101, 1, 4'b0101, 0);
        add(0, 32'h0,        4'b0000, 1, 1,  0, 32'h0,        4'b0000, 0, 4'b1000, 0);

        do_reset();
        check_all("reset", 0, 32'h0, 4'h0, 0, 4'b1000, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].rdy, tbl[i].clr);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_data, tbl[i].e_stat,
                      tbl[i].e_cnt, tbl[i].e_flags, tbl[i].e_drop);
        end

        // Test 3: full FIFO, push+pop every cycle across pointer wrap
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 32'hB000_0000 + 32'(k), 4'b1000, 0, 0);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'hB000_0000 + 32'(DEPTH + k), 4'b1000, 1, 0);
            step();
            check_all($sformatf("wrap%0d", k), 1, 32'hB000_0000 + 32'(k + 1), 4'b1000,
                      DEPTH, 4'b1000, 0);
        end

        // Test 6: asynchronous reset in the middle of a cycle
        do_reset();
        drive(1, 32'hC0000001, 4'b1000, 0, 0);
        step();
        drive(1, 32'hC0000002, 4'b1000, 0, 0);
        step();
        drive(0, 32'h0, 4'b0000, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_all("midrst", 0, 32'h0, 4'h0, 0, 4'b1000, 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 32'hC0000003, 4'b0001, 0, 0);
        step();
        check_all("postrst", 1, 32'hC0000003, 4'b0001, 1, 4'b0001, 0);

        // Random traffic against the queue model
        do_reset();
        mq.delete();
        mflags = 4'b1000;
        mdrop  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic        v, rdy, clr, mpop, mpush;
            logic [31:0] d;
            logic [3:0]  s;
            logic [35:0] head;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 4) < 2);
            clr = ($urandom_range(0, 15) == 0);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            drive(v, d, s, rdy, clr);

            mpop  = (mq.size() > 0) && rdy;
            mpush = v && ((mq.size() < DEPTH) || mpop);
            if (clr) begin
                mflags = 4'b1000;
                mdrop  = 1'b0;
            end
            if (v && !mpush) mdrop = 1'b1;
            if (mpush) begin
                mflags[3]   = mflags[3] & s[3];
                mflags[2:0] = mflags[2:0] | s[2:0];
            end
            if (mpop) void'(mq.pop_front());
            if (mpush) mq.push_back({s, d});

            step();
            head = (mq.size() > 0) ? mq[0] : 36'h0;
            check_all($sformatf("rnd%0d", n), mq.size() > 0, head[31:0], head[35:32],
                      mq.size(), mflags, mdrop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
